conv_encoder: RTL and testbench
===============================

CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 SHALL have parameter G1, default 7'o171, X-output generator (bit 6 = current input tap).
REQ-002 SHALL have parameter G2, default 7'o133, Y-output generator (bit 6 = current input tap).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_bits  input  1  randomized data bit from upstream randomizer.
REQ-006 SHALL have port in_valid  input  1  in_bits qualifier.
REQ-007 SHALL have port in_last  input  1  marks final data bit of burst; sampled with in_valid.
REQ-008 SHALL have port in_ready  output  1  bit accepted at edge where in_valid && in_ready.
REQ-009 SHALL have port rate  input  2  00=1/2, 01=2/3, 10=3/4, 11 treated as 1/2.
REQ-010 SHALL have port out_bits  output  1  coded, punctured serial bit.
REQ-011 SHALL have port out_valid  output  1  out_bits qualifier; no downstream backpressure.
REQ-012 SHALL have port out_last  output  1  high with final coded bit of burst only.
REQ-013 SHALL have port busy  output  1  high in DATA or TAIL or while pending bits remain.

Function
REQ-014 SHALL encode with K=7: window w = {b, sr[5:0]}, sr[5] most recent prior bit; X = ^(w & G1), Y = ^(w & G2); sr shifts in b after each encoded bit.
REQ-015 SHALL implement states IDLE, DATA, TAIL; IDLE->DATA on first accepted bit (or IDLE->TAIL if in_last also high); DATA->TAIL on accepted bit with in_last; TAIL->IDLE after 8th tail bit encoded.
REQ-016 SHALL on the first accepted bit of a burst: latch rate, clear sr to 0, clear puncture phase to 0; rate changes mid-burst ignored.
REQ-017 SHALL in TAIL encode 8 internally generated zero bits (0x00 tail byte), one per cycle when pending count <= 1, with same rate and continuing phase.
REQ-018 SHALL puncture per encoded bit by phase: 1/2 period 1: X,Y; 2/3 period 2: ph0 X,Y, ph1 Y; 3/4 period 3: ph0 X,Y, ph1 Y, ph2 X; emission order X before Y; phase wraps to 0 at period end.
REQ-019 SHALL hold emitted bits in a 2-entry pending buffer (count 0..2); each edge, if count>0, head moves to out_bits with out_valid=1, else out_valid=0, out_bits=0.
REQ-020 SHALL append bits of a bit encoded at an edge behind remaining pending bits at that same edge (drain and append simultaneous).
REQ-021 SHALL drive in_ready = (state is IDLE or DATA) && pending count <= 1, combinationally.
REQ-022 SHALL give latency: first coded bit of bit accepted at edge n is valid on out_bits after edge n+1.
REQ-023 SHALL ignore in_valid when in_ready low (bit not consumed; upstream holds it); ignore in_bits/in_last when in_valid low.
REQ-024 SHALL assert out_last with the final punctured bit derived from the 8th tail bit; busy falls the cycle after that bit is presented.
REQ-025 SHALL produce for N data bits (N+8 encoded) exactly 2(N+8) bits at 1/2, ceil(3(N+8)/2) at 2/3, and per-phase count at 3/4 (4 bits per 3 encoded).
REQ-026 SHALL accept a new burst's first bit in IDLE while previous burst's last pending bits still drain, with no gap or reordering.

Reset
REQ-027 SHALL on reset: state IDLE, sr=0, phase=0, pending count=0, out_bits=0, out_valid=0, out_last=0, busy=0, latched rate=00; in_ready=1 the cycle after.
REQ-028 SHALL abandon any burst on reset mid-operation: pending and tail bits discarded, no out_last emitted.

Verification
REQ-029 SHALL test rate=00, single bit 1 with in_last -> 18 bits 11 10 11 11 00 01 11 00 00, out_last on 18th.
REQ-030 SHALL test rate=10, single bit 1 with in_last -> 12 bits 1 1 0 1 1 1 0 0 1 1 0 0, out_last on 12th.
REQ-031 SHALL test rate=01, 10 all-zero bits with in_valid held high -> 27 zero bits, in_ready toggling, no lost input.
REQ-032 SHALL test reset asserted during TAIL -> next cycle out_valid=0, out_last never asserted, busy=0.
REQ-033 SHALL test two back-to-back bursts at rate 00 then 10 -> second burst uses 3/4 pattern from phase 0 with sr cleared, output stream contiguous.
REQ-034 SHALL test rate changed mid-burst and in_valid with in_ready low -> output unchanged vs. golden model.

Source files
------------

// File: rtl/conv_encoder.sv
// K=7 convolutional encoder with 1/2, 2/3 and 3/4 puncturing and a zero tail byte.
// Coded bits are serialised through a 2-entry pending buffer, one bit per clock.
module conv_encoder #(
  parameter logic [6:0] G1 = 7'o171,
  parameter logic [6:0] G2 = 7'o133
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_bits,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic [1:0] rate,
  output logic       out_bits,
  output logic       out_valid,
  output logic       out_last,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_TAIL
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_sr;
  logic [1:0] r_phase;
  logic [1:0] r_rate;
  logic [2:0] r_tail;
  logic [1:0] r_cnt;
  logic [1:0] r_pbit;
  logic [1:0] r_plast;
  logic       r_out_bits;
  logic       r_out_valid;
  logic       r_out_last;

  logic       w_in_ready;
  logic       w_accept;
  logic       w_first;
  logic       w_tail_enc;
  logic       w_enc;
  logic       w_b;
  logic       w_final;
  logic       w_x;
  logic       w_y;
  logic       w_emit_x;
  logic       w_emit_y;
  logic [5:0] w_sr_cur;
  logic [1:0] w_rate_cur;
  logic [1:0] w_phase_cur;
  logic [1:0] w_phase_nxt;
  logic [6:0] w_win;
  logic [1:0] w_cnt_nxt;
  logic [1:0] w_pbit_nxt;
  logic [1:0] w_plast_nxt;

  always_comb begin
    w_in_ready  = (r_state != S_TAIL) && (r_cnt <= 2'd1);
    w_accept    = in_valid && w_in_ready;
    w_first     = w_accept && (r_state == S_IDLE);
    w_tail_enc  = (r_state == S_TAIL) && (r_cnt <= 2'd1);
    w_enc       = w_accept || w_tail_enc;
    w_b         = w_accept & in_bits;
    w_final     = w_tail_enc && (r_tail == 3'd7);

    // A new burst starts from a cleared register, phase 0 and the rate on the port.
    w_sr_cur    = w_first ? '0 : r_sr;
    w_rate_cur  = w_first ? rate : r_rate;
    w_phase_cur = w_first ? '0 : r_phase;

    w_win = {w_b, w_sr_cur};
    w_x   = ^(w_win & G1);
    w_y   = ^(w_win & G2);

    w_emit_x    = 1'b1;
    w_emit_y    = 1'b1;
    w_phase_nxt = '0;
    case (w_rate_cur)
      2'b01: begin
        w_emit_x    = (w_phase_cur == 2'd0);
        w_emit_y    = 1'b1;
        w_phase_nxt = (w_phase_cur == 2'd0) ? 2'd1 : 2'd0;
      end
      2'b10: begin
        w_emit_x    = (w_phase_cur != 2'd1);
        w_emit_y    = (w_phase_cur != 2'd2);
        w_phase_nxt = (w_phase_cur == 2'd2) ? 2'd0 : w_phase_cur + 2'd1;
      end
      default: begin
        w_emit_x    = 1'b1;
        w_emit_y    = 1'b1;
        w_phase_nxt = '0;
      end
    endcase

    // Encoding only happens with count <= 1, so the head drains this same edge
    // and the buffer holds nothing but the freshly encoded bits afterwards.
    w_cnt_nxt   = r_cnt;
    w_pbit_nxt  = r_pbit;
    w_plast_nxt = r_plast;
    if (w_enc) begin
      if (w_emit_x && w_emit_y) begin
        w_cnt_nxt   = 2'd2;
        w_pbit_nxt  = {w_y, w_x};
        w_plast_nxt = {w_final, 1'b0};
      end else if (w_emit_x) begin
        w_cnt_nxt   = 2'd1;
        w_pbit_nxt  = {1'b0, w_x};
        w_plast_nxt = {1'b0, w_final};
      end else begin
        w_cnt_nxt   = 2'd1;
        w_pbit_nxt  = {1'b0, w_y};
        w_plast_nxt = {1'b0, w_final};
      end
    end else if (r_cnt != 2'd0) begin
      w_cnt_nxt   = r_cnt - 2'd1;
      w_pbit_nxt  = {1'b0, r_pbit[1]};
      w_plast_nxt = {1'b0, r_plast[1]};
    end

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = in_last ? S_TAIL : S_DATA;
      S_DATA:  if (w_accept && in_last) w_state_nxt = S_TAIL;
      S_TAIL:  if (w_final) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sr        <= '0;
      r_phase     <= '0;
      r_rate      <= '0;
      r_tail      <= '0;
      r_cnt       <= '0;
      r_pbit      <= '0;
      r_plast     <= '0;
      r_out_bits  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pbit      <= w_pbit_nxt;
      r_plast     <= w_plast_nxt;
      r_out_valid <= (r_cnt != 2'd0);
      r_out_bits  <= (r_cnt != 2'd0) & r_pbit[0];
      r_out_last  <= (r_cnt != 2'd0) & r_plast[0];
      if (w_enc) begin
        r_sr    <= w_win[6:1];
        r_phase <= w_phase_nxt;
      end
      if (w_first) r_rate <= rate;
      if (w_accept && in_last) r_tail <= '0;
      else if (w_tail_enc)     r_tail <= r_tail + 3'd1;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_bits  = r_out_bits;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  // Held through the cycle that presents the final bit, dropping one cycle later.
  assign busy      = (r_state != S_IDLE) || (r_cnt != 2'd0) || r_out_valid;

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: fixed vectors, corner sequences and random bursts
// compared against a tap-parity / puncture-pattern reference model.
module tb_conv_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_bits;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [1:0] rate;
  logic       out_bits;
  logic       out_valid;
  logic       out_last;
  logic       busy;

  always #5 clk = ~clk;

  conv_encoder #(.G1(7'o171), .G2(7'o133)) dut (
    .clk(clk), .reset(reset), .in_bits(in_bits), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .rate(rate), .out_bits(out_bits),
    .out_valid(out_valid), .out_last(out_last), .busy(busy)
  );

  localparam logic [6:0] MG1 = 7'o171;
  localparam logic [6:0] MG2 = 7'o133;

  typedef struct {
    logic [1:0]  rt;
    int unsigned n;
    logic [31:0] data;
    int unsigned len;
    logic [63:0] bits;
  } vec_t;

  int unsigned total = 0;
  int unsigned bad = 0;
  bit          din[128];
  bit          got_q[$];
  int          got_last[$];
  bit          exp_q[$];
  int          exp_last[$];
  int unsigned cyc = 0;
  int unsigned first_cyc = 0;
  int unsigned last_cyc = 0;
  int unsigned n_last = 0;
  int unsigned idle_bad = 0;
  int unsigned ready_low = 0;
  int unsigned base;
  vec_t        tbl[6];

  always @(negedge clk) begin
    cyc++;
    if (out_valid) begin
      if (got_q.size() == 0) first_cyc = cyc;
      last_cyc = cyc;
      if (out_last) begin
        got_last.push_back(got_q.size());
        n_last++;
      end
      got_q.push_back(out_bits);
    end else if (out_bits || out_last) begin
      idle_bad++;
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    got_last.delete();
    exp_q.delete();
    exp_last.delete();
  endtask

  // Reference: parity over the generator taps of the input history, then keep/drop by pattern.
  task automatic model_burst(input logic [1:0] rt, input int unsigned off, input int unsigned n);
    bit    u[$];
    string px;
    string py;
    int    per;
    for (int unsigned i = 0; i < n; i++) u.push_back(din[off+i]);
    for (int unsigned i = 0; i < 8; i++) u.push_back(1'b0);
    case (rt)
      2'b01:   begin px = "10";  py = "11";  end
      2'b10:   begin px = "101"; py = "110"; end
      default: begin px = "1";   py = "1";   end
    endcase
    per = px.len();
    for (int t = 0; t < u.size(); t++) begin
      bit x;
      bit y;
      x = 1'b0;
      y = 1'b0;
      for (int k = 0; k < 7; k++)
        if (t - k >= 0 && u[t-k]) begin
          x ^= MG1[6-k];
          y ^= MG2[6-k];
        end
      if (px[t % per] == "1") exp_q.push_back(x);
      if (py[t % per] == "1") exp_q.push_back(y);
    end
    exp_last.push_back(exp_q.size() - 1);
  endtask

  task automatic send_burst(input logic [1:0] rt, input int unsigned off, input int unsigned n,
                            input bit gaps, input bit jit);
    int unsigned i = 0;
    int unsigned guard = 0;
    while (i < n && guard < 2000) begin
      bit take;
      if (!gaps || ($urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_bits  = din[off+i];
        in_last  = (i == n - 1);
        rate     = (i == 0 || !jit) ? rt : 2'($urandom_range(0, 3));
      end else begin
        in_valid = 1'b0;
        in_bits  = 1'($urandom_range(0, 1));
        in_last  = 1'($urandom_range(0, 1));
        if (jit && i != 0) rate = 2'($urandom_range(0, 3));
      end
      take = in_valid && in_ready;
      if (in_valid && !in_ready) ready_low++;
      step();
      if (take) i++;
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("send_all_accepted", i, n);
  endtask

  task automatic wait_last(input int unsigned target, input string name);
    int unsigned g = 0;
    while (n_last < target && g < 1000) begin
      step();
      g++;
    end
    chk({name, "_done"}, (n_last >= target), 1);
  endtask

  task automatic check_stream(input string name);
    int unsigned mism = 0;
    chk({name, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] != exp_q[i]) mism++;
    chk({name, "_bits"}, mism, 0);
    mism = 0;
    chk({name, "_nlast"}, got_last.size(), exp_last.size());
    for (int i = 0; i < got_last.size() && i < exp_last.size(); i++)
      if (got_last[i] != exp_last[i]) mism++;
    chk({name, "_lastpos"}, mism, 0);
  endtask

  initial begin
    tbl[0] = '{2'b00, 1,  32'h1, 18, 64'b111011110001110000};
    tbl[1] = '{2'b10, 1,  32'h1, 12, 64'b110111001100};
    tbl[2] = '{2'b01, 10, 32'h0, 27, 64'h0};
    tbl[3] = '{2'b11, 1,  32'h1, 18, 64'b111011110001110000};
    tbl[4] = '{2'b10, 4,  32'h0, 16, 64'h0};
    tbl[5] = '{2'b01, 3,  32'h0, 17, 64'h0};

    reset = 1'b1; in_valid = 1'b0; in_bits = 1'b0; in_last = 1'b0; rate = 2'b00;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bits", out_bits, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    step();
    chk("rst_in_ready", in_ready, 1);

    // First-bit latency: accepted at edge n, visible after edge n+1.
    clear_obs();
    base = n_last;
    din[0] = 1'b1;
    in_valid = 1'b1; in_bits = 1'b1; in_last = 1'b1; rate = 2'b00;
    chk("lat_ready", in_ready, 1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("lat_edge_n_valid", out_valid, 0);
    step();
    chk("lat_edge_n1_valid", out_valid, 1);
    chk("lat_edge_n1_bit", out_bits, 1);
    model_burst(2'b00, 0, 1);
    wait_last(base + 1, "lat");
    check_stream("lat");
    step();

    for (int k = 0; k < 6; k++) begin
      clear_obs();
      base = n_last;
      ready_low = 0;
      for (int unsigned i = 0; i < tbl[k].n; i++) din[i] = tbl[k].data[i];
      for (int unsigned i = 0; i < tbl[k].len; i++) exp_q.push_back(tbl[k].bits[tbl[k].len-1-i]);
      exp_last.push_back(tbl[k].len - 1);
      send_burst(tbl[k].rt, 0, tbl[k].n, 1'b0, 1'b0);
      wait_last(base + 1, $sformatf("tbl%0d", k));
      check_stream($sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d_busy_on_last", k), busy, 1);
      if (tbl[k].n > 1) chk($sformatf("tbl%0d_ready_toggle", k), (ready_low > 0), 1);
      step();
      chk($sformatf("tbl%0d_busy_after", k), busy, 0);
      chk($sformatf("tbl%0d_valid_after", k), out_valid, 0);
    end

    // Reset in the middle of the tail.
    clear_obs();
    din[0] = 1'b1;
    send_burst(2'b00, 0, 1, 1'b0, 1'b0);
    repeat (6) step();
    reset = 1'b1;
    step();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_last", out_last, 0);
    chk("midrst_busy", busy, 0);
    reset = 1'b0;
    base = n_last;
    repeat (30) step();
    chk("midrst_no_last", n_last, base);
    chk("midrst_ready", in_ready, 1);

    // Back-to-back bursts, rate 1/2 then 3/4, input held valid.
    clear_obs();
    base = n_last;
    for (int i = 0; i < 11; i++) din[i] = 1'($urandom_range(0, 1));
    send_burst(2'b00, 0, 5, 1'b0, 1'b0);
    send_burst(2'b10, 5, 6, 1'b0, 1'b0);
    model_burst(2'b00, 0, 5);
    model_burst(2'b10, 5, 6);
    wait_last(base + 2, "b2b");
    check_stream("b2b");
    chk("b2b_contiguous", last_cyc - first_cyc + 1, got_q.size());
    step();
    chk("b2b_busy_after", busy, 0);

    // Random bursts with valid gaps and rate wiggling after the first bit.
    for (int r = 0; r < 10; r++) begin
      logic [1:0]  rt;
      int unsigned n;
      rt = 2'($urandom_range(0, 3));
      n  = $urandom_range(1, 24);
      clear_obs();
      base = n_last;
      for (int unsigned i = 0; i < n; i++) din[i] = 1'($urandom_range(0, 1));
      send_burst(rt, 0, n, 1'b1, 1'b1);
      model_burst(rt, 0, n);
      wait_last(base + 1, $sformatf("rnd%0d", r));
      check_stream($sformatf("rnd%0d", r));
      step();
    end

    chk("idle_outputs_zero", idle_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
